prio_encoder_seq: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 33 +++
 rtl/prio_rr_search.sv | 59 +++++
 rtl/prio_encoder_seq.sv | 101 ++++++++++
 tb/tb_prio_encoder_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg
// Shared definitions for the sequential priority encoder.
//   MODE_FIXED / MODE_RR : values of the rr_en input.
//   MAX_N                : widest request vector the helper functions accept.
//   highest_set()        : index of the most significant set bit (0 if none).
//   multi_hot()          : true when two or more bits are set.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Helper functions work on a fixed-width vector.
  // Callers zero-extend their N-bit request vector to this width.
  localparam int MAX_N = 256;

  // Scan upward so the last set bit seen (the highest one) wins.
  function automatic int unsigned highest_set(input logic [MAX_N-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [MAX_N-1:0] v);
    logic [MAX_N-1:0] low_cleared;
    low_cleared = v & (v - {{(MAX_N-1){1'b0}}, 1'b1});
    return (low_cleared != '0);
  endfunction

endpackage

// File: rtl/prio_rr_search.sv
// prio_rr_search
// Combinational wrap-around search: finds the first set bit of D,
// scanning upward from index start, past N-1, and around to start-1.
// Ports:
//   D     : request vector (N bits)
//   start : index where the search begins (must be < N)
//   idx   : index of the first set bit found (0 when none)
//   found : at least one bit of D is set
module prio_rr_search
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] D,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // rot[i] holds D[(start + i) mod N].
  // A plain lowest-set-bit search on rot then gives the distance from start.
  logic [N-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] pos;
      logic [W:0] pos_wrapped;
      assign pos         = {1'b0, start} + (W+1)'(gi);
      assign pos_wrapped = (pos >= (W+1)'(N)) ? pos - (W+1)'(N) : pos;
      assign rot[gi]     = D[pos_wrapped[W-1:0]];
    end
  endgenerate

  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    off   = '0;
    found = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (!found) begin
      idx = '0;
    end else if (sum >= (W+1)'(N)) begin
      idx = W'(sum - (W+1)'(N));
    end else begin
      idx = sum[W-1:0];
    end
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// prio_encoder_seq
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// In fixed mode the highest set index wins.
// In round-robin mode the search starts just after the previous winner.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   D         : request vector, qualified by in_valid
//   in_valid  : D and rr_en are valid
//   in_ready  : block can accept D this cycle
//   rr_en     : 0 = fixed priority, 1 = round-robin (sampled with D)
//   Y         : encoded winning index
//   zero      : accepted D was all zeros
//   multi     : accepted D had two or more bits set
//   out_valid : Y, zero and multi are valid
//   out_ready : downstream takes the result this cycle
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] D,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rr_en,
  output logic [W-1:0] Y,
  output logic         zero,
  output logic         multi,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] y_reg;
  logic         zero_reg;
  logic         multi_reg;
  logic         out_valid_reg;
  logic [W-1:0] ptr_reg;

  logic         accept;
  logic [W-1:0] rr_start;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] fixed_idx;
  logic         d_multi;
  logic         d_zero;
  logic [MAX_N-1:0] d_ext;

  // A result can be replaced whenever it is absent or being consumed now.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  assign d_ext     = MAX_N'(D);
  assign fixed_idx = W'(highest_set(d_ext));
  assign d_multi   = multi_hot(d_ext);
  assign d_zero    = (D == '0);

  // The pointer holds the last RR winner, so the search begins one past it.
  assign rr_start = (ptr_reg == W'(N - 1)) ? '0 : ptr_reg + 1'b1;

  prio_rr_search #(.N(N)) u_rr_search (
    .D     (D),
    .start (rr_start),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg         <= '0;
      zero_reg      <= 1'b0;
      multi_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= W'(N - 1);
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      zero_reg      <= d_zero;
      multi_reg     <= d_multi;
      if (d_zero) begin
        y_reg <= '0;
      end else if (rr_en == MODE_RR) begin
        y_reg <= rr_idx;
      end else begin
        y_reg <= fixed_idx;
      end
      // An all-zero request has no winner, so the pointer stays put.
      if (rr_en == MODE_RR && rr_found) begin
        ptr_reg <= rr_idx;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign Y         = y_reg;
  assign zero      = zero_reg;
  assign multi     = multi_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_prio_encoder_seq.sv
module tb_prio_encoder_seq;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct {
    logic [W-1:0] y;
    logic         zero;
    logic         multi;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] D = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         rr_en = 1'b0;
  logic [W-1:0] Y;
  logic         zero;
  logic         multi;
  logic         out_valid;
  logic         out_ready = 1'b1;

  prio_encoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .Y         (Y),
    .zero      (zero),
    .multi     (multi),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t pend;
  logic pend_valid = 1'b0;
  int   mptr = N - 1;
  logic do_pop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: straight from the encoding rules.
  function automatic exp_t model(input logic [N-1:0] d, input logic rr);
    exp_t e;
    e.y     = '0;
    e.zero  = (d == '0);
    e.multi = ($countones(d) >= 2);
    if (d != '0) begin
      if (!rr) begin
        for (int j = N - 1; j >= 0; j--) begin
          if (d[j]) begin
            e.y = W'(j);
            break;
          end
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (mptr + k) % N;
          if (d[j]) begin
            e.y  = W'(j);
            mptr = j;
            break;
          end
        end
      end
    end
    return e;
  endfunction

  // One cycle of stimulus; an accepted request becomes visible after the next edge.
  task automatic drive(input logic [N-1:0] d, input logic v, input logic rr, input logic ordy);
    logic exp_ready;
    @(posedge clk);
    if (pend_valid) begin
      q.push_back(pend);
      pend_valid = 1'b0;
    end
    #1;
    D = d;
    in_valid = v;
    rr_en = rr;
    out_ready = ordy;
    @(negedge clk);
    exp_ready = (q.size() == 0) || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (v && exp_ready) begin
      pend = model(d, rr);
      pend_valid = 1'b1;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    if (pend_valid) begin
      q.push_back(pend);
      pend_valid = 1'b0;
    end
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    q.delete();
    mptr = N - 1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Monitor: compares presented results against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("Y", 32'(Y), 32'(q[0].y));
        chk("zero", 32'(zero), 32'(q[0].zero));
        chk("multi", 32'(multi), 32'(q[0].multi));
      end
      do_pop = out_valid && out_ready && (q.size() != 0);
    end else begin
      do_pop = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (do_pop && q.size() != 0) begin
      $display("txn Y=%0d zero=%0b multi=%0b", q[0].y, q[0].zero, q[0].multi);
      void'(q.pop_front());
    end
  end

  initial begin
    // Reset for two cycles.
    do_reset(2);

    // Fixed mode sequence.
    drive(8'h80, 1, 0, 1);
    drive(8'h01, 1, 0, 1);
    drive(8'h00, 1, 0, 1);
    drive(8'h05, 1, 0, 1);
    drive(8'h00, 0, 0, 1);

    // Round-robin from reset.
    do_reset(1);
    repeat (4) drive(8'hFF, 1, 1, 1);
    drive(8'h09, 1, 1, 1);
    drive(8'h81, 1, 1, 1);
    drive(8'h00, 0, 1, 1);

    // Round-robin with all-zero: ptr=2 first.
    do_reset(1);
    drive(8'h04, 1, 1, 1);
    drive(8'h00, 1, 1, 1);
    drive(8'h0C, 1, 1, 1);
    drive(8'h00, 0, 1, 1);

    // Backpressure.
    drive(8'h10, 1, 0, 1);
    drive(8'h33, 1, 0, 0);
    drive(8'hC0, 1, 1, 0);
    drive(8'h07, 1, 0, 0);
    drive(8'h02, 1, 0, 1);
    drive(8'h00, 0, 0, 1);

    // Reset mid-hold with ptr=5.
    do_reset(1);
    drive(8'h20, 1, 1, 1);
    drive(8'h08, 1, 1, 0);
    drive(8'h00, 0, 1, 0);
    do_reset(1);
    drive(8'h41, 1, 1, 1);
    drive(8'h00, 0, 1, 1);

    // Randomized traffic, with mode switching and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = N'(1) << $urandom_range(0, N - 1);
        default: d = N'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        drive(d, ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 3) != 0));
      end
    end

    // Drain.
    repeat (3) drive(8'h00, 0, 0, 1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
